// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: program counter plus a single-outstanding instruction fetch
// with memory handshake, timeout abort and decoded instruction fields.
module instr_fetch_unit #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_pulse,
    input  logic              pc_pulse,
    input  logic [1:0]        pc_ctrl,
    input  logic [ADDR_W-1:0] pc_target,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic              fetch_done,
    output logic [3:0]        opcode,
    output logic [1:0]        rd,
    output logic [1:0]        rs,
    output logic [ADDR_W-1:0] pc,
    output logic              fetch_err
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t             state;
    logic [INSTR_W-1:0] ir;
    logic [ADDR_W-1:0]  fetch_addr;
    logic [CW-1:0]      wait_cnt;

    assign mem_addr = fetch_addr;
    assign opcode   = ir[7:4];
    assign rd       = ir[3:2];
    assign rs       = ir[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ir         <= '0;
            fetch_addr <= '0;
            wait_cnt   <= '0;
            mem_req    <= 1'b0;
            fetch_done <= 1'b0;
            fetch_err  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (fetch_pulse) begin
                        state      <= REQ;
                        fetch_addr <= pc;
                        wait_cnt   <= '0;
                        mem_req    <= 1'b1;
                        fetch_done <= 1'b0;
                        fetch_err  <= 1'b0;
                    end
                end
                REQ: begin
                    // fetch_pulse is deliberately ignored while a request is outstanding
                    if (mem_ack) begin
                        ir         <= mem_rdata;
                        state      <= DONE;
                        mem_req    <= 1'b0;
                        fetch_done <= 1'b1;
                    end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                        state     <= IDLE;
                        mem_req   <= 1'b0;
                        fetch_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pc <= '0;
        else if (pc_pulse)
            pc <= (pc_ctrl == 2'b01) ? pc + 1'b1 :
                  (pc_ctrl == 2'b10) ? pc_target :
                  (pc_ctrl == 2'b11) ? '0 : pc;
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed checks of fetch handshake, timeout, PC ops and reset.
module tb_instr_fetch_unit;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fetch_pulse = 1'b0;
    logic       pc_pulse = 1'b0;
    logic [1:0] pc_ctrl = 2'b00;
    logic [7:0] pc_target = 8'h00;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       mem_ack = 1'b0;
    logic [7:0] mem_rdata = 8'h00;
    logic       fetch_done;
    logic [3:0] opcode;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [7:0] pc;
    logic       fetch_err;

    int tests = 0;
    int fails = 0;

    instr_fetch_unit dut (
        .clk(clk), .rst(rst), .fetch_pulse(fetch_pulse), .pc_pulse(pc_pulse),
        .pc_ctrl(pc_ctrl), .pc_target(pc_target), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .fetch_done(fetch_done), .opcode(opcode), .rd(rd), .rs(rs),
        .pc(pc), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #1;
        check("rst_pc", pc, 8'h00);
        check("rst_req", mem_req, 1'b0);
        check("rst_done", fetch_done, 1'b0);
        check("rst_err", fetch_err, 1'b0);
        check("rst_ir", {opcode, rd, rs}, 8'h00);
        check("rst_addr", mem_addr, 8'h00);
        tick(); tick();
        rst = 1'b0;
        tick();

        // fetch + pc increment same cycle, zero-wait ack of 0x8D
        fetch_pulse = 1'b1; pc_pulse = 1'b1; pc_ctrl = 2'b01;
        tick();
        fetch_pulse = 1'b0; pc_pulse = 1'b0; pc_ctrl = 2'b00;
        check("t1_req", mem_req, 1'b1);
        check("t1_addr", mem_addr, 8'h00);
        check("t1_pc", pc, 8'h01);
        check("t1_done_early", fetch_done, 1'b0);
        mem_ack = 1'b1; mem_rdata = 8'h8D;
        tick();
        mem_ack = 1'b0; mem_rdata = 8'h00;
        check("t1_done", fetch_done, 1'b1);
        check("t1_req_drop", mem_req, 1'b0);
        check("t1_opcode", opcode, 4'h8);
        check("t1_rd", rd, 2'd3);
        check("t1_rs", rs, 2'd1);

        // 5 wait cycles then ack: mem_req high 6 cycles, garbage rdata not captured
        fetch_pulse = 1'b1;
        tick();
        fetch_pulse = 1'b0;
        mem_rdata = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            check("t2_req_wait", mem_req, 1'b1);
            check("t2_addr_wait", mem_addr, 8'h01);
            check("t2_ir_hold", {opcode, rd, rs}, 8'h8D);
            check("t2_done_wait", fetch_done, 1'b0);
            tick();
        end
        check("t2_req_6th", mem_req, 1'b1);
        mem_ack = 1'b1; mem_rdata = 8'h5A;
        tick();
        mem_ack = 1'b0; mem_rdata = 8'h00;
        check("t2_done", fetch_done, 1'b1);
        check("t2_ir", {opcode, rd, rs}, 8'h5A);
        check("t2_rd", rd, 2'd2);

        // ack outside REQ ignored
        mem_ack = 1'b1; mem_rdata = 8'h33;
        tick();
        mem_ack = 1'b0;
        check("stray_ack_ir", {opcode, rd, rs}, 8'h5A);
        check("stray_ack_done", fetch_done, 1'b1);

        // timeout after 15 wait cycles
        fetch_pulse = 1'b1;
        tick();
        fetch_pulse = 1'b0;
        check("t3_done_fall", fetch_done, 1'b0);
        for (int i = 0; i < 14; i++) tick();
        check("t3_req_14", mem_req, 1'b1);
        check("t3_err_14", fetch_err, 1'b0);
        tick();
        check("t3_req_drop", mem_req, 1'b0);
        check("t3_err", fetch_err, 1'b1);
        check("t3_done", fetch_done, 1'b0);
        check("t3_ir", {opcode, rd, rs}, 8'h5A);
        tick();
        check("t3_err_sticky", fetch_err, 1'b1);
        fetch_pulse = 1'b1;
        tick();
        fetch_pulse = 1'b0;
        check("t3_err_clr", fetch_err, 1'b0);
        check("t3_refetch_req", mem_req, 1'b1);
        mem_ack = 1'b1; mem_rdata = 8'hC4;
        tick();
        mem_ack = 1'b0;
        check("t3_refetch_ir", {opcode, rd, rs}, 8'hC4);

        // PC operations
        pc_pulse = 1'b1; pc_ctrl = 2'b10; pc_target = 8'hFF;
        tick();
        check("pc_load", pc, 8'hFF);
        pc_ctrl = 2'b01;
        tick();
        check("pc_wrap", pc, 8'h00);
        pc_ctrl = 2'b10; pc_target = 8'h42;
        tick();
        pc_ctrl = 2'b00;
        tick();
        check("pc_hold", pc, 8'h42);
        pc_pulse = 1'b0; pc_ctrl = 2'b01;
        tick();
        check("pc_nopulse", pc, 8'h42);
        pc_pulse = 1'b1; pc_ctrl = 2'b11;
        tick();
        check("pc_clear", pc, 8'h00);
        pc_ctrl = 2'b10; pc_target = 8'h10;
        tick();
        pc_pulse = 1'b0; pc_ctrl = 2'b00;

        // second fetch_pulse during REQ ignored
        fetch_pulse = 1'b1;
        tick();
        check("t5_addr", mem_addr, 8'h10);
        pc_pulse = 1'b1; pc_ctrl = 2'b01;
        tick();
        pc_pulse = 1'b0; pc_ctrl = 2'b00; fetch_pulse = 1'b0;
        check("t5_addr_stable", mem_addr, 8'h10);
        check("t5_req_still", mem_req, 1'b1);
        mem_ack = 1'b1; mem_rdata = 8'h27;
        tick();
        mem_ack = 1'b0;
        check("t5_done", fetch_done, 1'b1);
        tick();
        check("t5_no_second_req", mem_req, 1'b0);
        check("t5_still_done", fetch_done, 1'b1);

        // reset mid-fetch
        fetch_pulse = 1'b1;
        tick();
        fetch_pulse = 1'b0;
        check("t6_req", mem_req, 1'b1);
        rst = 1'b1;
        #1;
        check("t6_rst_req", mem_req, 1'b0);
        check("t6_rst_pc", pc, 8'h00);
        check("t6_rst_ir", {opcode, rd, rs}, 8'h00);
        check("t6_rst_addr", mem_addr, 8'h00);
        tick();
        rst = 1'b0;
        mem_ack = 1'b1; mem_rdata = 8'h99;
        tick();
        mem_ack = 1'b0;
        check("t6_late_ack_ir", {opcode, rd, rs}, 8'h00);
        check("t6_late_ack_done", fetch_done, 1'b0);
        check("t6_late_ack_req", mem_req, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 8, width of program counter and instruction memory address.
REQ-002 Parameter INSTR_W, default 8, instruction width; layout [7:4] opcode, [3:2] rd, [1:0] rs.
REQ-003 Parameter TIMEOUT, default 15, maximum cycles spent waiting for mem_ack before an abort.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 fetch_pulse  input  1  one-cycle fetch request from the control FSM.
REQ-007 pc_pulse  input  1  one-cycle PC update strobe from the control FSM.
REQ-008 pc_ctrl  input  2  PC operation: 00 hold, 01 increment, 10 load pc_target, 11 clear to zero.
REQ-009 pc_target  input  ADDR_W  branch/load target.
REQ-010 mem_req  output  1  memory read request, held high until accepted.
REQ-011 mem_addr  output  ADDR_W  read address; stable while mem_req is high.
REQ-012 mem_ack  input  1  memory has valid mem_rdata this cycle.
REQ-013 mem_rdata  input  INSTR_W  instruction word, sampled only when mem_ack is high.
REQ-014 fetch_done  output  1  level; instruction register valid (drives the FSM fetch-done input).
REQ-015 opcode  output  4  ir[7:4]; rd  output  2  ir[3:2]; rs  output  2  ir[1:0].
REQ-016 pc  output  ADDR_W  current program counter.
REQ-017 fetch_err  output  1  sticky; set on timeout, cleared by the next accepted fetch_pulse.

Function
REQ-018 FSM states: IDLE, REQ, DONE; encoding is implementation choice.
REQ-019 IDLE: fetch_pulse=1 -> latch fetch_addr<=pc (pre-update value), goto REQ next cycle.
REQ-020 REQ: mem_req=1, mem_addr=fetch_addr; mem_ack=1 -> ir<=mem_rdata, goto DONE.
REQ-021 REQ: wait counter increments each cycle mem_ack=0; reaching TIMEOUT -> drop mem_req, set fetch_err, ir unchanged, goto IDLE.
REQ-022 DONE: fetch_done=1; remains in DONE until fetch_pulse, which behaves exactly as in IDLE (fetch_done falls the following cycle).
REQ-023 fetch_pulse while in REQ is ignored; there is no queueing and no error.
REQ-024 mem_req rises the cycle after the accepted fetch_pulse; response latency is 2 cycles from fetch_pulse with a zero-wait memory (fetch_done high on the 2nd edge after the pulse).
REQ-025 PC updates only on pc_pulse, independent of FSM state; increment wraps modulo 2^ADDR_W (0xFF+1 -> 0x00).
REQ-026 fetch_pulse and pc_pulse in the same cycle: fetch uses the old pc; the new pc is visible the next cycle.
REQ-027 pc_pulse=1 with pc_ctrl=00 leaves pc unchanged.
REQ-028 opcode/rd/rs are combinational slices of ir and hold their value until the next successful fetch.
REQ-029 mem_ack outside REQ is ignored.

Reset
REQ-030 rst=1 forces immediately: state IDLE, pc=0, ir=0, fetch_addr=0, wait counter=0, mem_req=0, fetch_done=0, fetch_err=0.
REQ-031 rst asserted mid-fetch aborts the transaction (mem_req low immediately); a late mem_ack after reset release is ignored.

Verification
REQ-032 Reset, pc_pulse with pc_ctrl=01 plus fetch_pulse in the same cycle, mem acks in 1 cycle with 0x8D -> mem_addr=0x00, pc=0x01, opcode=0x8, rd=3, rs=1, fetch_done high 2 cycles after the pulse.
REQ-033 Memory acks after a 5-cycle wait -> mem_req held 6 cycles with mem_addr stable, ir captured only on the ack cycle.
REQ-034 Memory never acks -> after 15 wait cycles mem_req=0, fetch_err=1, fetch_done=0; the next fetch_pulse clears fetch_err.
REQ-035 pc_ctrl=10 with pc_target=0xFF, then pc_ctrl=01 -> pc=0xFF then 0x00; pc_ctrl=11 -> 0x00.
REQ-036 Second fetch_pulse during REQ -> ignored, single mem transaction; rst pulse during REQ -> all outputs at reset values.
